mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit holding the HI/LO pair, downstream of the register file.
//  - Consumes rs/rt read data (read_data_1/read_data_2) for MULT/MULTU/DIV/DIVU.
//  - Result lands in HI/LO. HI/LO are read back via MFHI/MFLO and written via MTHI/MTLO.
//  - Control stalls the PC while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits; product is 2*WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      launch operation; sampled only in IDLE
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  operand_a  in   WIDTH  rs value (multiplicand / dividend)
//  operand_b  in   WIDTH  rt value (multiplier / divisor)
//  hi_write   in   1      MTHI: load write_data into HI
//  lo_write   in   1      MTLO: load write_data into LO
//  write_data in   WIDTH  MTHI/MTLO data
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
//  busy       out  1      operation in flight; start, hi_write and lo_write are ignored
//  done       out  1      one-cycle pulse: HI/LO just updated by a mul/div
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; hi=lo=busy=done=0; internal accumulators cleared.
//  Reset mid-operation aborts the operation; HI/LO are NOT written with a partial result.
//  States:
//   IDLE  -> MUL  when start and op[1]=0
//   IDLE  -> DIV  when start and op[1]=1
//   MUL/DIV -> FIX after WIDTH iterations; a counter runs 0..WIDTH-1
//   FIX   -> IDLE writes HI/LO and pulses done
//  Edge numbering: the start edge (E0) captures operands and op. Signed ops take magnitudes at E0.
//  MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
//  DIV: restoring divide, one quotient bit per cycle.
//  FIX: signed ops negate the product if operand signs differ.
//   Quotient sign = XOR of operand signs; remainder sign = dividend sign.
//  Latency: HI/LO and done update at edge E(WIDTH+1), i.e. E33 for the default width.
//   busy=1 after E0 until E(WIDTH+1); done=1 only for the cycle after E(WIDTH+1).
//  Result mapping:
//   mul: HI=product[2W-1:W], LO=product[W-1:0]
//   div: LO=quotient, HI=remainder
//  Divide by zero: LO={WIDTH{1'b1}}, HI=operand_a (raw dividend). Same latency, no exception.
//  DIV of most-negative by -1: LO=most-negative (wraps), HI=0.
//  IDLE writes: hi_write/lo_write take effect at the next edge; both may be asserted together.
//  start together with hi_write/lo_write in IDLE: start wins, the writes are dropped.
//  start, hi_write and lo_write are ignored while busy.
//  Back-to-back: start may be asserted in the cycle done is high (state is IDLE then).
//  Operands need not be held after E0.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   - MULT/MULTU use a single-cycle 2*WIDTH multiply; state goes IDLE -> FIX at E0.
//   - HI/LO and done update at E1; busy is high for one cycle.
//   - DIV/DIVU are unchanged.
//  MULDIV_FAST_MUL_EN undefined: iterative multiply as above; no multiplier inferred.
// TESTING
//  1. MULT a=FFFFFFFD (-3), b=00000005 -> at E33: HI=FFFFFFFF, LO=FFFFFFF1, done=1 for 1 cycle.
//     With the fast macro: same values at E1.
//  2. MULTU a=b=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; busy high for exactly 33 cycles.
//  3. DIV a=FFFFFFF9 (-7), b=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
//     DIVU a=00000007, b=00000002 -> LO=00000003, HI=00000001.
//  4. DIVU a=00001234, b=00000000 -> LO=FFFFFFFF, HI=00001234 at E33.
//     DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=00000000.
//  5. While busy: pulse start with new operands and hi_write with data=DEADBEEF -> both ignored;
//     first result intact. In IDLE, start+lo_write together -> start wins, LO gets the result.
//  6. Drop rst_n at E10 of a MULT with prior HI/LO=11111111 -> immediately hi=lo=0, busy=0,
//     no done pulse. After release, a new DIVU completes normally.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO (shift-add multiply, restoring divide).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply path for MULT/MULTU.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       mcand_q, mcand_d;
   logic [WIDTH-1:0]       dvd_q, dvd_d;
   logic                   is_div_q, is_div_d;
   logic                   neg_q, neg_d;
   logic                   neg_rem_q, neg_rem_d;
   logic                   bzero_q, bzero_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic                   done_q, done_d;

   logic                   signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]       a_mag, b_mag;
   logic [WIDTH:0]         mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quot_fix, rem_fix;

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & operand_a[WIDTH-1];
   assign b_neg     = signed_op & operand_b[WIDTH-1];
   assign a_mag     = a_neg ? -operand_a : operand_a;
   assign b_mag     = b_neg ? -operand_b : operand_b;

   // acc holds {partial product, remaining multiplier} during MUL, {remainder, quotient} during DIV
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand_q};

   assign prod_fix  = neg_q ? -acc_q : acc_q;
   assign quot_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      dvd_d     = dvd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d     = operand_a;
               is_div_d  = op[1];
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               bzero_d   = (operand_b == '0);
               cnt_d     = '0;
               if (op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  mcand_d = b_mag;
                  state_d = S_DIV;
               end else begin
                  mcand_d = a_mag;
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                  state_d = S_FIX;
`else
                  acc_d   = {{WIDTH{1'b0}}, b_mag};
                  state_d = S_MUL;
`endif
               end
            end else begin
               if (hi_write) hi_d = write_data;
               if (lo_write) lo_d = write_data;
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_DIV: begin
            // Restore by keeping the unsubtracted shift when the trial subtraction borrows
            acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               if (bzero_q) begin
                  lo_d = {WIDTH{1'b1}};
                  hi_d = dvd_q;
               end else begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         dvd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         dvd_q     <= dvd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: reference results queued at launch, compared on done.
module tb_mips_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  operand_a, operand_b;
   logic          hi_write, lo_write;
   logic [W-1:0]  write_data;
   logic [W-1:0]  hi, lo;
   logic          busy, done;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result {HI, LO} from native SV arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] r;
      longint      sp;
      int          sa, sb, q, rm;
      sa = a;
      sb = b;
      case (o)
         2'b00: begin
            sp = longint'(sa) * longint'(sb);
            r  = sp;
         end
         2'b01: r = {32'h0, a} * {32'h0, b};
         default: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else if (o == 2'b10) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
               else begin
                  q  = sa / sb;
                  rm = sa % sb;
                  r  = {rm, q};
               end
            end else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input bit with_lo, input string tag);
      exp_t        e;
      logic [63:0] m;
      int          cyc, busy_cnt;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      if (with_lo) begin
         lo_write   = 1'b1;
         write_data = 32'hA5A5_A5A5;
      end
      m    = model(o, a, b);
      e.hi = m[63:32];
      e.lo = m[31:0];
      e.lat = o[1] ? DIV_LAT : MUL_LAT;
      sb_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; lo_write = 1'b0;
      operand_a = $urandom; operand_b = $urandom;
      cyc = 0;
      busy_cnt = 0;
      while (!done && cyc < 200) begin
         if (busy) busy_cnt++;
         if (disturb && cyc == 4) begin
            start = 1'b1; op = 2'b01; operand_a = 32'h0000_0003; operand_b = 32'h0000_0005;
            hi_write = 1'b1; write_data = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; hi_write = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; hi_write = 1'b0;
      e = sb_q.pop_front();
      check_eq({tag, " latency"}, 64'(cyc), 64'(e.lat));
      check_eq({tag, " busy cycles"}, 64'(busy_cnt), 64'(e.lat));
      check_eq({tag, " hi"}, {32'h0, hi}, {32'h0, e.hi});
      check_eq({tag, " lo"}, {32'h0, lo}, {32'h0, e.lo});
      $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h (cycles %0d)", tag, o, a, b, hi, lo, cyc);
      @(posedge clk); #1;
      check_eq({tag, " done one cycle"}, {63'h0, done}, 64'h0);
      check_eq({tag, " idle after"}, {63'h0, busy}, 64'h0);
   endtask

   task automatic write_hilo(input bit wh, input bit wl, input logic [W-1:0] d);
      @(negedge clk);
      hi_write = wh; lo_write = wl; write_data = d;
      @(posedge clk); #1;
      hi_write = 1'b0; lo_write = 1'b0;
   endtask

   initial begin
      int done_seen;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
      hi_write = 1'b0; lo_write = 1'b0; write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset hi", {32'h0, hi}, 64'h0);
      check_eq("reset lo", {32'h0, lo}, 64'h0);
      check_eq("reset busy", {63'h0, busy}, 64'h0);
      check_eq("reset done", {63'h0, done}, 64'h0);
      @(negedge clk) rst_n = 1'b1;

      write_hilo(1'b1, 1'b1, 32'h1111_1111);
      check_eq("mthi+mtlo hi", {32'h0, hi}, 64'h1111_1111);
      check_eq("mthi+mtlo lo", {32'h0, lo}, 64'h1111_1111);
      write_hilo(1'b1, 1'b0, 32'h3333_3333);
      check_eq("mthi hi", {32'h0, hi}, 64'h3333_3333);
      check_eq("mthi lo kept", {32'h0, lo}, 64'h1111_1111);
      $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, "mult -3*5");
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu max");
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, "div -7/2");
      run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, "divu 7/2");
      run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, "divu by0");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div ovf");
      run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1, 1'b0, "div busy-ignore");
      run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, "mult start+mtlo");

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? 32'h0 : $urandom;
         if (i == 2) rb = rb >> 20;
         run_op(ro, ra, rb, 1'b0, 1'b0, $sformatf("rand%0d", i));
      end

      // Reset mid-operation: no partial result, no done pulse
      write_hilo(1'b1, 1'b1, 32'h1111_1111);
      @(negedge clk);
      start = 1'b1; op = 2'b00; operand_a = 32'h0000_0007; operand_b = 32'h0000_0009;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("abort hi", {32'h0, hi}, 64'h0);
      check_eq("abort lo", {32'h0, lo}, 64'h0);
      check_eq("abort busy", {63'h0, busy}, 64'h0);
      check_eq("abort done", {63'h0, done}, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check_eq("abort no done", 64'(done_seen), 64'h0);
      $display("txn reset-abort hi=%h lo=%h busy=%b", hi, lo, busy);
      run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0, "divu after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
